// File: rtl/jtag_seq_master.sv
// Command-driven JTAG master. It turns RESET / SHIFT_IR / SHIFT_DR / IDLE commands
// into TCK/TMS/TDI/TRSTn sequences and returns the captured TDO bits right-aligned.
module jtag_seq_master #(
  parameter int MAX_LEN  = 64,
  parameter int CLK_DIV  = 2,
  parameter int RST_TCKS = 5,
  parameter int LEN_W    = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               tck,
  output logic               tms,
  output logic               tdi,
  output logic               trstn,
  input  logic               tdo
);

  localparam int RST_W = $clog2(RST_TCKS + 1);
  localparam int CNT_W = (LEN_W > RST_W) ? LEN_W : RST_W;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [1:0]       OP_RESET = 2'd0;
  localparam logic [1:0]       OP_IR    = 2'd1;
  localparam logic [1:0]       OP_IDLE  = 2'd3;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_TCKS);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);

  typedef enum logic [2:0] {
    ST_IDLE, ST_PRE, ST_SHIFT, ST_POST, ST_RST, ST_RTI_WAIT
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [DIV_W-1:0]   div_reg, div_next;
  logic               phase_reg, phase_next;
  logic [1:0]         op_reg, op_next;
  logic [LEN_W-1:0]   len_reg, len_next;
  logic [MAX_LEN-1:0] data_reg, data_next;
  logic [MAX_LEN-1:0] cap_reg, cap_next;
  logic               tck_reg, tck_next;
  logic               tms_reg, tms_next;
  logic               tdi_reg, tdi_next;
  logic               trstn_reg, trstn_next;
  logic               rsp_valid_reg, rsp_valid_next;
  logic [MAX_LEN-1:0] rsp_data_reg, rsp_data_next;

  logic               accept, sample_en, load, finish;
  state_t             ld_state;
  logic [CNT_W-1:0]   ld_cnt;
  logic [1:0]         ld_op;
  logic [LEN_W-1:0]   shift_len;
  logic [CNT_W-1:0]   len_m1, pre_last;

  assign shift_len = (cmd_len == '0) ? LEN_W'(1) : ((cmd_len > LEN_MAX) ? LEN_MAX : cmd_len);
  assign len_m1    = CNT_W'(len_reg) - CNT_W'(1);
  assign pre_last  = (op_reg == OP_IR) ? CNT_W'(3) : CNT_W'(2);

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    div_next       = div_reg;
    phase_next     = phase_reg;
    op_next        = op_reg;
    len_next       = len_reg;
    data_next      = data_reg;
    tck_next       = tck_reg;
    tms_next       = tms_reg;
    tdi_next       = tdi_reg;
    trstn_next     = trstn_reg;
    rsp_valid_next = 1'b0;
    rsp_data_next  = rsp_data_reg;
    accept         = 1'b0;
    sample_en      = 1'b0;
    load           = 1'b0;
    finish         = 1'b0;
    ld_state       = state_reg;
    ld_cnt         = cnt_reg;
    ld_op          = op_reg;

    if (state_reg == ST_IDLE) begin
      trstn_next = 1'b1;
      if (cmd_valid) begin
        accept     = 1'b1;
        load       = 1'b1;
        ld_op      = cmd_op;
        ld_cnt     = '0;
        op_next    = cmd_op;
        data_next  = cmd_data;
        div_next   = '0;
        phase_next = 1'b0;
        case (cmd_op)
          OP_RESET: begin ld_state = ST_RST;      len_next = cmd_len;   end
          OP_IDLE:  begin ld_state = ST_RTI_WAIT; len_next = cmd_len;   end
          default:  begin ld_state = ST_PRE;      len_next = shift_len; end
        endcase
      end
    end else if (state_reg == ST_RTI_WAIT && len_reg == '0) begin
      state_next = ST_IDLE;
    end else if (div_reg != DIV_LAST) begin
      div_next = div_reg + DIV_W'(1);
    end else begin
      div_next   = '0;
      phase_next = !phase_reg;
      if (!phase_reg) begin
        tck_next  = 1'b1;
        sample_en = (state_reg == ST_SHIFT);
      end else begin
        // End of a TCK: step the sequence and set up TMS/TDI for the next one.
        tck_next = 1'b0;
        ld_cnt   = cnt_reg + CNT_W'(1);
        case (state_reg)
          ST_RST:   if (cnt_reg == RST_LAST) finish = 1'b1;
          ST_PRE:   if (cnt_reg == pre_last) begin ld_state = ST_SHIFT; ld_cnt = '0; end
          ST_SHIFT: if (cnt_reg == len_m1) begin ld_state = ST_POST; ld_cnt = '0; end
          ST_POST:  if (cnt_reg == CNT_W'(1)) finish = 1'b1;
          default:  if (cnt_reg == len_m1) finish = 1'b1;
        endcase
        load = !finish;
      end
    end

    if (finish) begin
      state_next = ST_IDLE;
      tdi_next   = 1'b0;
      if (state_reg == ST_POST) begin
        rsp_valid_next = 1'b1;
        rsp_data_next  = cap_reg;
      end
    end

    if (load) begin
      state_next = ld_state;
      cnt_next   = ld_cnt;
      tdi_next   = 1'b0;
      trstn_next = 1'b1;
      case (ld_state)
        ST_RST: begin
          tms_next   = (ld_cnt != RST_LAST);
          trstn_next = (ld_cnt == RST_LAST);
        end
        ST_PRE:   tms_next = (ld_cnt == '0) || (ld_op == OP_IR && ld_cnt == CNT_W'(1));
        ST_SHIFT: begin
          tms_next  = (ld_cnt == len_m1);
          tdi_next  = data_reg[0];
          data_next = data_reg >> 1;
        end
        ST_POST:  tms_next = (ld_cnt == '0);
        default:  tms_next = 1'b0;
      endcase
    end
  end

  // Each capture bit is written only on the TCK rise of its own shift position.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_LEN; gi++) begin : g_cap
      assign cap_next[gi] = accept ? 1'b0 :
                            ((sample_en && cnt_reg == CNT_W'(gi)) ? tdo : cap_reg[gi]);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      div_reg       <= '0;
      phase_reg     <= 1'b0;
      op_reg        <= '0;
      len_reg       <= '0;
      data_reg      <= '0;
      cap_reg       <= '0;
      tck_reg       <= 1'b0;
      tms_reg       <= 1'b1;
      tdi_reg       <= 1'b0;
      trstn_reg     <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      div_reg       <= div_next;
      phase_reg     <= phase_next;
      op_reg        <= op_next;
      len_reg       <= len_next;
      data_reg      <= data_next;
      cap_reg       <= cap_next;
      tck_reg       <= tck_next;
      tms_reg       <= tms_next;
      tdi_reg       <= tdi_next;
      trstn_reg     <= trstn_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_data_reg  <= rsp_data_next;
    end
  end

  assign cmd_ready = (state_reg == ST_IDLE);
  assign busy      = !cmd_ready;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign tck       = tck_reg;
  assign tms       = tms_reg;
  assign tdi       = tdi_reg;
  assign trstn     = trstn_reg;

endmodule

// File: tb/tb_jtag_seq_master.sv
// Bench for jtag_seq_master: command vector table, a behavioural TAP model on the
// pins, and a response scoreboard fed at issue time and drained on rsp_valid.
module tb_jtag_seq_master;

  localparam int MAX_LEN  = 64;
  localparam int CLK_DIV  = 2;
  localparam int RST_TCKS = 5;
  localparam int LEN_W    = $clog2(MAX_LEN + 1);

  localparam logic [1:0] OP_RESET = 2'd0;
  localparam logic [1:0] OP_IR    = 2'd1;
  localparam logic [1:0] OP_DR    = 2'd2;
  localparam logic [1:0] OP_IDLE  = 2'd3;

  localparam logic [MAX_LEN-1:0] IR_CAPTURE = 64'h1;
  localparam logic [MAX_LEN-1:0] DR_CAPTURE = 64'h0123_4567_89AB_CDEF;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [1:0]         cmd_op = '0;
  logic [LEN_W-1:0]   cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic               rsp_valid;
  logic [MAX_LEN-1:0] rsp_data;
  logic               busy, tck, tms, tdi, trstn, tdo;
  logic               tdo_mode = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  jtag_seq_master #(.MAX_LEN(MAX_LEN), .CLK_DIV(CLK_DIV), .RST_TCKS(RST_TCKS)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
    .tck(tck), .tms(tms), .tdi(tdi), .trstn(trstn), .tdo(tdo)
  );

  // Behavioural TAP controller; tdo loops back tdi or comes from its shift register.
  typedef enum logic [3:0] {
    TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
    SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR
  } tap_t;
  tap_t               tap_st;
  logic [MAX_LEN-1:0] tap_sr = '0;

  function automatic tap_t tap_step(input tap_t s, input logic m);
    case (s)
      TLR:     return m ? TLR   : RTI;
      RTI:     return m ? SELDR : RTI;
      SELDR:   return m ? SELIR : CAPDR;
      CAPDR:   return m ? EX1DR : SHDR;
      SHDR:    return m ? EX1DR : SHDR;
      EX1DR:   return m ? UPDR  : PADR;
      PADR:    return m ? EX2DR : PADR;
      EX2DR:   return m ? UPDR  : SHDR;
      UPDR:    return m ? SELDR : RTI;
      SELIR:   return m ? TLR   : CAPIR;
      CAPIR:   return m ? EX1IR : SHIR;
      SHIR:    return m ? EX1IR : SHIR;
      EX1IR:   return m ? UPIR  : PAIR;
      PAIR:    return m ? EX2IR : PAIR;
      EX2IR:   return m ? UPIR  : SHIR;
      default: return m ? SELDR : RTI;
    endcase
  endfunction

  always @(posedge tck or negedge trstn) begin
    if (!trstn) begin
      tap_st <= TLR;
    end else begin
      tap_st <= tap_step(tap_st, tms);
      if (tap_st == CAPIR)                    tap_sr <= IR_CAPTURE;
      else if (tap_st == CAPDR)               tap_sr <= DR_CAPTURE;
      else if (tap_st == SHIR || tap_st == SHDR) tap_sr <= {1'b0, tap_sr[MAX_LEN-1:1]};
    end
  end

  assign tdo = tdo_mode ? tap_sr[0] : tdi;

  logic [1:0] tck_log[$];
  always @(posedge tck) tck_log.push_back({trstn, tms});

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  logic [MAX_LEN-1:0] exp_q[$];
  logic [MAX_LEN-1:0] sb_exp;
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: rsp_data=%0h, required no response", rsp_data);
      end else begin
        sb_exp = exp_q.pop_front();
        check("rsp_data", {64'h0, rsp_data}, {64'h0, sb_exp});
      end
    end
  end

  function automatic logic exp_tms(input logic [1:0] op, input int n, input int i);
    int p;
    if (op == OP_RESET) return (i < RST_TCKS);
    if (op == OP_IDLE)  return 1'b0;
    p = (op == OP_IR) ? 4 : 3;
    if (i < p)     return (i == 0) || (op == OP_IR && i == 1);
    if (i < p + n) return (i == p + n - 1);
    return (i == p + n);
  endfunction

  typedef struct {
    logic [1:0]  op;
    int          len;
    logic [63:0] data;
    bit          mode;
    int          tcks;
    int          cycles;
    bit          has_rsp;
    logic [63:0] rsp;
  } vec_t;

  vec_t vecs[10];

  task automatic run_cmd(input vec_t v, input string tag);
    int cyc;
    int n;
    logic [127:0] tms_a, tms_e, trs_a, trs_e;
    tdo_mode = v.mode;
    tck_log.delete();
    if (v.has_rsp) exp_q.push_back(v.rsp);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = v.op;
    cmd_len   = LEN_W'(v.len);
    cmd_data  = v.data;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = ~v.op;
    cmd_len   = ~LEN_W'(v.len);
    cmd_data  = ~v.data;
    cyc = 0;
    while (!cmd_ready && cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_cycles"}, 128'(cyc), 128'(v.cycles));
    check({tag, "_rsp_valid"}, 128'(rsp_valid), 128'(v.has_rsp));
    check({tag, "_tck_idle_low"}, 128'(tck), 128'h0);
    check({tag, "_tck_count"}, 128'(tck_log.size()), 128'(v.tcks));
    n = v.tcks - ((v.op == OP_IR) ? 6 : 5);
    tms_a = '0; tms_e = '0; trs_a = '0; trs_e = '0;
    for (int i = 0; i < tck_log.size() && i < 128; i++) begin
      tms_a[i] = tck_log[i][0];
      trs_a[i] = tck_log[i][1];
    end
    for (int i = 0; i < v.tcks && i < 128; i++) begin
      tms_e[i] = exp_tms(v.op, n, i);
      trs_e[i] = !(v.op == OP_RESET && i < RST_TCKS);
    end
    check({tag, "_tms_pattern"}, tms_a, tms_e);
    check({tag, "_trstn_pattern"}, trs_a, trs_e);
    check({tag, "_tap_in_rti"}, 128'(tap_st), 128'(RTI));
    $display("cmd %s op=%0d len=%0d tcks=%0d cycles=%0d rsp_valid=%0b rsp_data=%0h",
             tag, v.op, v.len, tck_log.size(), cyc, rsp_valid, rsp_data);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    vecs[0] = '{OP_RESET, 0,   64'h0,                   1'b0, 6,  24,  1'b0, 64'h0};
    vecs[1] = '{OP_DR,    32,  64'hDEAD_BEEF,           1'b0, 37, 148, 1'b1, 64'hDEAD_BEEF};
    vecs[2] = '{OP_IR,    4,   64'h5,                   1'b1, 10, 40,  1'b1, 64'h1};
    vecs[3] = '{OP_DR,    0,   64'hFF,                  1'b0, 6,  24,  1'b1, 64'h1};
    vecs[4] = '{OP_DR,    127, 64'hA5A5_0F0F_1234_8765, 1'b0, 69, 276, 1'b1, 64'hA5A5_0F0F_1234_8765};
    vecs[5] = '{OP_IDLE,  0,   64'h0,                   1'b0, 0,  1,   1'b0, 64'h0};
    vecs[6] = '{OP_IDLE,  10,  64'h0,                   1'b0, 10, 40,  1'b0, 64'h0};
    vecs[7] = '{OP_IR,    8,   64'h3C,                  1'b0, 14, 56,  1'b1, 64'h3C};
    vecs[8] = '{OP_DR,    5,   64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 10, 40,  1'b1, 64'h1F};
    vecs[9] = '{OP_DR,    16,  64'h0,                   1'b1, 21, 84,  1'b1, 64'hCDEF};

    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tck", 128'(tck), 128'h0);
    check("rst_tms", 128'(tms), 128'h1);
    check("rst_tdi", 128'(tdi), 128'h0);
    check("rst_trstn", 128'(trstn), 128'h0);
    check("rst_cmd_ready", 128'(cmd_ready), 128'h1);
    check("rst_busy", 128'(busy), 128'h0);
    check("rst_rsp_valid", 128'(rsp_valid), 128'h0);
    check("rst_rsp_data", {64'h0, rsp_data}, 128'h0);
    @(negedge clk) rst = 1'b0;
    #1 check("trstn_before_first_edge", 128'(trstn), 128'h0);
    @(posedge clk);
    #1 check("trstn_after_first_edge", 128'(trstn), 128'h1);

    for (int i = 0; i < 10; i++) run_cmd(vecs[i], $sformatf("vec%0d", i));

    // Abort a 32-bit DR shift part-way through with an asynchronous reset.
    tdo_mode = 1'b0;
    tck_log.delete();
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = OP_DR;
    cmd_len   = LEN_W'(32);
    cmd_data  = 64'h1234_5678;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    cyc = 0;
    while (tck_log.size() < 13 && cyc < 1000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check("abort_reached_bit10", 128'(tck_log.size()), 128'd13);
    #2 rst = 1'b1;
    #1;
    check("abort_tck", 128'(tck), 128'h0);
    check("abort_tms", 128'(tms), 128'h1);
    check("abort_tdi", 128'(tdi), 128'h0);
    check("abort_trstn", 128'(trstn), 128'h0);
    check("abort_cmd_ready", 128'(cmd_ready), 128'h1);
    check("abort_busy", 128'(busy), 128'h0);
    check("abort_rsp_valid", 128'(rsp_valid), 128'h0);
    check("abort_rsp_data", {64'h0, rsp_data}, 128'h0);
    $display("cmd abort op=2 len=32 tcks_before_rst=%0d", tck_log.size());
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    run_cmd(vecs[0], "post_abort_reset");
    run_cmd(vecs[1], "post_abort_shift");

    repeat (4) @(posedge clk);
    #1 check("scoreboard_drained", 128'(exp_q.size()), 128'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
